score_bcd_counter: RTL



---
 rtl/score_pkg.sv | 27 ++
 rtl/bcd_digit_add.sv | 22 ++
 rtl/score_bcd_counter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared types, default point values and the line-count to BCD addend mapping
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

    localparam logic [15:0] PTS_1_DEF = 16'h0040;
    localparam logic [15:0] PTS_2_DEF = 16'h0100;
    localparam logic [15:0] PTS_3_DEF = 16'h0300;
    localparam logic [15:0] PTS_4_DEF = 16'h1200;

    // 0 lines scores nothing; 5..7 clamp to the 4-line value
    function automatic logic [15:0] lines_to_addend(
        input logic [2:0]  lines,
        input logic [15:0] p1,
        input logic [15:0] p2,
        input logic [15:0] p3,
        input logic [15:0] p4
    );
        return (lines == 3'd0) ? 16'h0000 :
               (lines == 3'd1) ? p1 :
               (lines == 3'd2) ? p2 :
               (lines == 3'd3) ? p3 : p4;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one-digit BCD adder with decimal carry
//   a, b : BCD digits in
//   cin  : carry in
//   sum  : BCD digit out
//   cout : decimal carry out
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] w_bin;

    assign w_bin = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign cout  = w_bin > 5'd9;
    assign sum   = cout ? 4'(w_bin + 5'd6) : w_bin[3:0];

endmodule

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: accumulates line-clear events into a saturating packed-BCD score, one digit per cycle
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous score clear, overrides everything
//   in_valid  : event valid, in_lines = lines cleared, in_ready = slot free
//   level     : (SCORE_LEVEL_MULT_EN only) addend is added level+1 times
//   busy      : addition running or event pending
//   done      : one-cycle pulse when score updates
//   score     : packed BCD, digit 0 in [3:0]
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int          DIGITS = 6,
    parameter logic [15:0] PTS_1  = PTS_1_DEF,
    parameter logic [15:0] PTS_2  = PTS_2_DEF,
    parameter logic [15:0] PTS_3  = PTS_3_DEF,
    parameter logic [15:0] PTS_4  = PTS_4_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [2:0]          in_lines,
`ifdef SCORE_LEVEL_MULT_EN
    input  logic [3:0]          level,
`endif
    output logic                in_ready,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] score
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

    state_t         r_state, w_state_nx;
    logic [W-1:0]   r_score, r_work, r_addend, r_pend_addend;
    logic [W-1:0]   w_new_addend, w_load_addend, w_commit_val;
    logic [IW-1:0]  r_idx;
    logic [IW+1:0]  w_sel;
    logic           r_carry, r_pend_valid, r_done;
    logic           w_accept, w_start_new, w_last, w_final, w_ovf, w_load, w_cout;
    bcd_digit_t     w_sum;
`ifdef SCORE_LEVEL_MULT_EN
    logic [3:0]     r_level, r_pass, r_pend_level, w_load_level;
    logic           r_sat;
`endif

    assign in_ready     = ~r_pend_valid;
    assign busy         = (r_state != IDLE) | r_pend_valid;
    assign done         = r_done;
    assign score        = r_score;
    assign w_accept     = in_valid & in_ready & ~clear;
    assign w_start_new  = w_accept & (in_lines != 3'd0);
    assign w_new_addend = W'(lines_to_addend(in_lines, PTS_1, PTS_2, PTS_3, PTS_4));
    assign w_last       = r_idx == IW'(DIGITS - 1);
    assign w_sel        = {r_idx, 2'b00};
`ifdef SCORE_LEVEL_MULT_EN
    assign w_final      = w_last & (r_pass == r_level);
    assign w_ovf        = r_sat;
    assign w_load_level = r_pend_valid ? r_pend_level : level;
`else
    assign w_final      = w_last;
    assign w_ovf        = r_carry;
`endif
    assign w_commit_val = w_ovf ? ALL9 : r_work;
    // pending slot is always empty in IDLE, so it only takes priority at COMMIT
    assign w_load        = ((r_state == IDLE) & w_start_new) |
                           ((r_state == COMMIT) & (r_pend_valid | w_start_new));
    assign w_load_addend = r_pend_valid ? r_pend_addend : w_new_addend;

    bcd_digit_add u_add (
        .a    (r_work[w_sel +: 4]),
        .b    (r_addend[w_sel +: 4]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = clear               ? IDLE :
                     (r_state == ADD)    ? (w_final ? COMMIT : ADD) :
                     w_load              ? ADD : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score       <= '0;
            r_work        <= '0;
            r_addend      <= '0;
            r_pend_addend <= '0;
            r_pend_valid  <= 1'b0;
            r_idx         <= '0;
            r_carry       <= 1'b0;
            r_done        <= 1'b0;
`ifdef SCORE_LEVEL_MULT_EN
            r_level       <= '0;
            r_pass        <= '0;
            r_pend_level  <= '0;
            r_sat         <= 1'b0;
`endif
        end else if (clear) begin
            r_score      <= '0;
            r_pend_valid <= 1'b0;
            r_idx        <= '0;
            r_carry      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= r_state == COMMIT;
            if (r_state == COMMIT) r_score <= w_commit_val;
            if (w_start_new && r_state == ADD) begin
                r_pend_valid  <= 1'b1;
                r_pend_addend <= w_new_addend;
`ifdef SCORE_LEVEL_MULT_EN
                r_pend_level  <= level;
`endif
            end else if (r_state == COMMIT) begin
                r_pend_valid <= 1'b0;
            end
            if (w_load) begin
                r_addend <= w_load_addend;
                // a back-to-back event builds on the value being committed this cycle
                r_work   <= (r_state == COMMIT) ? w_commit_val : r_score;
                r_carry  <= 1'b0;
                r_idx    <= '0;
`ifdef SCORE_LEVEL_MULT_EN
                r_level  <= w_load_level;
                r_pass   <= '0;
                r_sat    <= 1'b0;
`endif
            end else if (r_state == ADD) begin
                r_work[w_sel +: 4] <= w_sum;
                r_idx              <= w_last ? '0 : r_idx + 1'b1;
`ifdef SCORE_LEVEL_MULT_EN
                // top-digit carry is overflow: latch it and start the next pass clean
                r_carry <= w_cout & ~w_last;
                r_sat   <= r_sat | (w_last & w_cout);
                r_pass  <= r_pass + 4'(w_last);
`else
                r_carry <= w_cout;
`endif
            end
        end
    end

endmodule
